// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle controller and its ALU decoder.
// Build option: MC_CONTROL_JUMP_EN adds the JUMP and JR states.
package mc_control_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StItypeEx = 4'd8,
    StItypeWb = 4'd9,
    StBranch  = 4'd10
`ifdef MC_CONTROL_JUMP_EN
    ,
    StJump    = 4'd11,
    StJr      = 4'd12
`endif
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnJr   = 6'b001000;

  // ALU operation codes
  localparam logic [3:0] AluNone = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0001;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;
  localparam logic [3:0] AluNor  = 4'b0101;
  localparam logic [3:0] AluSlt  = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode/funct decoder: ALU op for R-type and I-type forms plus
// an instruction-legality flag. Honours MC_CONTROL_JUMP_EN for j/jr legality.
module mc_alu_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_r_o,
  output logic [3:0] alu_i_o,
  output logic       legal_o
);

  logic r_legal;

  // Decode funct and opcode into ALU ops and a legality flag.
  always_comb begin
    alu_r_o = AluNone;
    r_legal = 1'b1;
    case (funct_i)
      FnAdd, FnAddu: alu_r_o = AluAdd;
      FnSub, FnSubu: alu_r_o = AluSub;
      FnAnd:         alu_r_o = AluAnd;
      FnOr:          alu_r_o = AluOr;
      FnNor:         alu_r_o = AluNor;
      FnSlt:         alu_r_o = AluSlt;
      FnSll:         alu_r_o = AluSll;
      FnSrl:         alu_r_o = AluSrl;
      FnSra:         alu_r_o = AluSra;
`ifdef MC_CONTROL_JUMP_EN
      FnJr:          alu_r_o = AluNone;
`endif
      default:       r_legal = 1'b0;
    endcase

    alu_i_o = AluNone;
    legal_o = 1'b1;
    case (opcode_i)
      OpAddi, OpAddiu: alu_i_o = AluAdd;
      OpAndi:          alu_i_o = AluAnd;
      OpOri:           alu_i_o = AluOr;
      OpSlti:          alu_i_o = AluSlt;
      OpLw, OpSw, OpBeq: legal_o = 1'b1;
      OpRtype:         legal_o = r_legal;
`ifdef MC_CONTROL_JUMP_EN
      OpJ:             legal_o = 1'b1;
`endif
      default:         legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style controller: Moore FSM whose strobes are decoded from
// the state register (FETCH strobes additionally gated by mem_ready).
// Build option: MC_CONTROL_JUMP_EN enables the JUMP/JR states.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned ALUOP_W       = 4,
  parameter int unsigned MEM_WAIT_EN_P = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state_o,
  output logic               illegal_o
);

  state_e     state_q;
  logic [5:0] opcode_q, funct_q;
  logic [5:0] dec_opcode, dec_funct;
  logic [3:0] alu_r, alu_i, alu;
  logic       legal, ready;

  assign ready = (MEM_WAIT_EN_P != 0) ? mem_ready : 1'b1;

  // In DECODE the live instruction is checked; elsewhere the latched copy drives ALUOp.
  assign dec_opcode = (state_q == StDecode) ? opcode : opcode_q;
  assign dec_funct  = (state_q == StDecode) ? funct  : funct_q;

  mc_alu_decode u_alu_decode (
    .opcode_i (dec_opcode),
    .funct_i  (dec_funct),
    .alu_r_o  (alu_r),
    .alu_i_o  (alu_i),
    .legal_o  (legal)
  );

  // State register, instruction latch and transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      if (state_q == StDecode) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      unique case (state_q)
        StFetch:  if (ready) state_q <= StDecode;
        StDecode: begin
          if (!legal) begin
            state_q <= StFetch;
          end else begin
            case (opcode)
              OpLw, OpSw: state_q <= StMemAdr;
`ifdef MC_CONTROL_JUMP_EN
              OpRtype:    state_q <= (funct == FnJr) ? StJr : StRtypeEx;
              OpJ:        state_q <= StJump;
`else
              OpRtype:    state_q <= StRtypeEx;
`endif
              OpBeq:      state_q <= StBranch;
              OpAddi, OpAddiu, OpAndi, OpOri, OpSlti: state_q <= StItypeEx;
              default:    state_q <= StFetch;
            endcase
          end
        end
        StMemAdr:  state_q <= (opcode_q == OpSw) ? StMemWr : StMemRd;
        StMemRd:   if (ready) state_q <= StMemWb;
        StMemWr:   if (ready) state_q <= StFetch;
        StRtypeEx: state_q <= StRtypeWb;
        StItypeEx: state_q <= StItypeWb;
        default:   state_q <= StFetch;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    alu         = AluNone;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = ready;
        PCWrite = ready;
        ALUSrcB = 2'b01;
        alu     = AluAdd;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        alu     = AluAdd;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu     = AluAdd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        alu     = alu_r;
      end
      StRtypeWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StItypeEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu     = alu_i;
      end
      StItypeWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA     = 1'b1;
        alu         = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
`ifdef MC_CONTROL_JUMP_EN
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StJr: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
`endif
      default: ;
    endcase
    ALUOp = ALUOP_W'(alu);
  end

  assign state_o   = state_q;
  assign illegal_o = (state_q == StDecode) && !legal;

endmodule
